// File: rtl/tb_mem_arb_pkg.sv
// Shared types, limits and the round-robin pick helper for the testbench
// RAM port arbiter.
package tb_mem_arb_pkg;

  localparam int MAX_REQ     = 8;
  localparam int MAX_LATENCY = 4;

  // One in-flight response tag: which requester the RAM slot belongs to.
  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } arb_tag_t;

  // Round-robin pick: search upward from last+1, wrapping at num_req; the
  // first eligible requester wins. Returns a one-hot vector, or zero when
  // nothing is eligible.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] eligible,
    input logic [2:0]         last,
    input logic [3:0]         num_req
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    logic [3:0]         idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= num_req) begin
        idx = idx - num_req;
      end else begin
        idx = idx;
      end
      if (!found && (4'(k) <= num_req) && eligible[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/tb_mem_arb_tag_pipe.sv
// Fixed-depth shift register carrying {valid, id} tags alongside the RAM
// access so each response can be steered back to its issuer.
module tb_mem_arb_tag_pipe
  import tb_mem_arb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  arb_tag_t tag_i,
  output arb_tag_t tag_o
);

  arb_tag_t [LATENCY-1:0] stage_r;

  // Shift every cycle; reset discards every in-flight tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= tag_i;
      for (int s = 1; s < LATENCY; s++) begin
        stage_r[s] <= stage_r[s-1];
      end
    end
  end

  assign tag_o = stage_r[LATENCY-1];

endmodule

// File: rtl/tb_mem_port_arbiter.sv
// Round-robin arbiter sharing the single testbench RAM port between the
// core fetch, core data and debug/loader masters. Responses are routed back
// through a tag pipeline matching the RAM latency; a saturating counter
// records cycles with contention.
module tb_mem_port_arbiter
  import tb_mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]                   we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_i,
  input  logic                                 lock_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   rvalid_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 ram_req_o,
  output logic [ADDR_WIDTH-1:0]                ram_addr_o,
  output logic                                 ram_we_o,
  output logic [DATA_WIDTH/8-1:0]              ram_be_o,
  output logic [DATA_WIDTH-1:0]                ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]                ram_rdata_i,
  output logic [31:0]                          conflict_cnt_o
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [MAX_REQ-1:0] eligible_s;
  logic [MAX_REQ-1:0] pick_s;
  logic [2:0]         win_s;
  logic               conflict_s;
  logic [2:0]         rr_last_r;
  logic [31:0]        conflict_cnt_r;
  arb_tag_t           tag_in_s;
  arb_tag_t           tag_out_s;

  // Eligibility: lock restricts to requester 0; nothing is eligible in reset.
  always_comb begin
    eligible_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_s[i] = req_i[i] & rst_ni & (~lock_i | (i == 0));
    end
  end

  // Round-robin pick, winner index and contention detect.
  always_comb begin
    pick_s     = rr_pick(eligible_s, rr_last_r, 4'(NUM_REQ));
    gnt_o      = pick_s[NUM_REQ-1:0];
    conflict_s = |(eligible_s & (eligible_s - 8'd1));
    win_s      = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick_s[i]) begin
        win_s = 3'(i);
      end else begin
        win_s = win_s;
      end
    end
  end

  // Forward the winner's address phase to the RAM; idle port drives zero.
  always_comb begin
    ram_req_o   = |gnt_o;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_o[i]) begin
        ram_addr_o  = addr_i[i];
        ram_we_o    = we_i[i];
        ram_be_o    = be_i[i];
        ram_wdata_o = wdata_i[i];
      end else begin
        ram_addr_o  = ram_addr_o;
      end
    end
  end

  // Round-robin pointer and saturating contention counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_last_r      <= 3'(NUM_REQ - 1);
      conflict_cnt_r <= 32'd0;
    end else begin
      if (ram_req_o) begin
        rr_last_r <= win_s;
      end else begin
        rr_last_r <= rr_last_r;
      end
      if (conflict_s && (conflict_cnt_r != 32'hFFFF_FFFF)) begin
        conflict_cnt_r <= conflict_cnt_r + 32'd1;
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end
  end

  assign conflict_cnt_o = conflict_cnt_r;
  assign tag_in_s       = '{valid: ram_req_o, id: win_s};

  tb_mem_arb_tag_pipe #(
    .LATENCY (RAM_LATENCY)
  ) u_tag_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (tag_in_s),
    .tag_o  (tag_out_s)
  );

  // Decode the emerging tag into a one-hot response valid.
  always_comb begin
    rvalid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_o[i] = tag_out_s.valid & (tag_out_s.id == 3'(i));
    end
  end

  assign rdata_o = ram_rdata_i;

endmodule
